// File: rtl/weighted_rr_arbiter.sv
// weighted_rr_arbiter: strobe-driven round-robin arbiter with per-requester quotas and burst lock
module weighted_rr_arbiter #(
  parameter int N = 8,
  parameter int WEIGHT_W = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [N-1:0]          req,
  input  logic [N*WEIGHT_W-1:0] weight,
  input  logic [N-1:0]          lock,
  output logic [N-1:0]          gnt,
  output logic                  gnt_valid,
  output logic [ID_W-1:0]       gnt_id,
  output logic                  gnt_new
);
  logic [ID_W-1:0] owner, ptr, pick;
  logic [WEIGHT_W-1:0] cnt;
  logic valid, found, hold;
  assign hold = valid & req[owner] & (lock[owner] | (cnt < weight[int'(owner)*WEIGHT_W +: WEIGHT_W]));
  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int i = N-1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        pick = ID_W'((int'(ptr) + i) % N);
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= '0;
      ptr <= '0;
      cnt <= '0;
      valid <= 1'b0;
      gnt <= '0;
      gnt_new <= 1'b0;
    end else if (ena) begin
      gnt_new <= 1'b0;
      if (hold) cnt <= &cnt ? cnt : cnt + 1'b1;
      else if (found) begin
        owner <= pick;
        valid <= 1'b1;
        cnt <= '0;
        ptr <= (int'(pick) == N-1) ? '0 : pick + 1'b1;
        gnt <= N'(1) << pick;
        gnt_new <= 1'b1;
      end else begin
        owner <= '0;
        valid <= 1'b0;
        gnt <= '0;
      end
    end else gnt_new <= 1'b0;
  end
  assign gnt_valid = valid;
  assign gnt_id = owner;
endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// tb_weighted_rr_arbiter: directed checks of weighted round-robin arbitration with N=4
module tb_weighted_rr_arbiter;
  localparam int N = 4;
  localparam int WEIGHT_W = 4;
  logic clk = 0, rst = 1, ena = 0;
  logic [N-1:0] req = '0, lock = '0, gnt;
  logic [N*WEIGHT_W-1:0] weight = '0;
  logic gnt_valid, gnt_new;
  logic [1:0] gnt_id;
  int checks = 0, failures = 0;

  weighted_rr_arbiter #(.N(N), .WEIGHT_W(WEIGHT_W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .weight(weight), .lock(lock),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .gnt_new(gnt_new)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_g(input string tag, input logic [N-1:0] g, input logic n);
    logic [1:0] id;
    id = '0;
    for (int i = 0; i < N; i++) if (g[i]) id = 2'(i);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".new"}, 32'(gnt_new), 32'(n));
    chk({tag, ".id"}, 32'(gnt_id), 32'(id));
    chk({tag, ".valid"}, 32'(gnt_valid), 32'(|g));
  endtask

  task automatic strobe();
    repeat (3) @(negedge clk);
    ena = 1;
    @(negedge clk);
    ena = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    ena = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    do_reset();
    expect_g("reset", 4'b0000, 0);

    req = 4'b1111;
    strobe(); expect_g("t1.s1", 4'b0001, 1);
    strobe(); expect_g("t1.s2", 4'b0010, 1);
    strobe(); expect_g("t1.s3", 4'b0100, 1);
    strobe(); expect_g("t1.s4", 4'b1000, 1);
    strobe(); expect_g("t1.s5", 4'b0001, 1);

    do_reset();
    weight = 16'h0002;
    strobe(); expect_g("t2.s1", 4'b0001, 1);
    strobe(); expect_g("t2.s2", 4'b0001, 0);
    strobe(); expect_g("t2.s3", 4'b0001, 0);
    strobe(); expect_g("t2.s4", 4'b0010, 1);
    strobe(); expect_g("t2.s5", 4'b0100, 1);
    strobe(); expect_g("t2.s6", 4'b1000, 1);
    strobe(); expect_g("t2.s7", 4'b0001, 1);

    do_reset();
    weight = 16'h0030;
    req = 4'b0010;
    strobe(); expect_g("t3.own", 4'b0010, 1);
    req = 4'b1111;
    lock = 4'b0011;
    for (int i = 0; i < 17; i++) strobe();
    expect_g("t3.locked", 4'b0010, 0);
    lock = 4'b0000;
    strobe(); expect_g("t3.release", 4'b0100, 1);

    do_reset();
    weight = 16'h0003;
    req = 4'b1111;
    strobe(); expect_g("t4.s1", 4'b0001, 1);
    req = 4'b1110;
    strobe(); expect_g("t4.drop", 4'b0010, 1);

    do_reset();
    weight = '0;
    req = 4'b0001;
    strobe(); expect_g("regrant.s1", 4'b0001, 1);
    strobe(); expect_g("regrant.s2", 4'b0001, 1);

    do_reset();
    req = 4'b0100;
    strobe(); expect_g("t5.own", 4'b0100, 1);
    req = 4'b0000;
    strobe(); expect_g("t5.idle1", 4'b0000, 0);
    strobe(); strobe(); expect_g("t5.idle3", 4'b0000, 0);
    req = 4'b1111;
    strobe(); expect_g("t5.ptr", 4'b1000, 1);
    req = 4'b0001;
    repeat (5) @(negedge clk);
    expect_g("t5.noena", 4'b1000, 0);

    do_reset();
    weight = 16'h3000;
    req = 4'b1000;
    strobe(); expect_g("t6.own", 4'b1000, 1);
    strobe(); strobe(); expect_g("t6.burst", 4'b1000, 0);
    rst = 1;
    @(negedge clk);
    expect_g("t6.rst", 4'b0000, 0);
    rst = 0;
    req = 4'b1111;
    strobe(); expect_g("t6.after", 4'b0001, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
